// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the word-level RAM request controller.
// Exports: state_e (controller FSM states), OP_RD / OP_WR request opcodes.
package ram_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  // Value of req_wr selecting each operation
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/ram_word_ctrl_if.sv
// Request/response bus between a requester and the RAM word controller.
// Request:  req_valid, req_ready, req_wr, req_addr[AW], req_wdata[WIDTH]
// Response: rsp_valid, rsp_ready, rsp_rdata[WIDTH], rsp_err
// master = requester side, slave = controller side.
interface ram_word_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) ();

  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/ram_addr_decode.sv
// Binary-to-one-hot word select decoder with enable and range flag.
// Ports: en_i (gate for onehot_o), addr_i[AW] word address,
//        onehot_o[DEPTH] one-hot select (zero when disabled or out of range),
//        out_of_range_o asserted when addr_i >= DEPTH (independent of en_i).
module ram_addr_decode #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  output logic [DEPTH-1:0] onehot_o,
  output logic             out_of_range_o
);

  always_comb begin
    out_of_range_o = (32'(addr_i) >= DEPTH);
    onehot_o       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (en_i && (32'(addr_i) == i)) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_word_ctrl.sv
// Request-side controller for a 1-bit-cell RAM array: accepts word
// read/write requests, strobes SEL/READ/IN with array-safe timing, captures
// OUT on reads and returns exactly one response per accepted request.
// Ports: clk, rst_n (async, active-low)
//        bus     : request/response handshake (slave side)
//        sel_o   : one-hot word select to the array
//        read_o  : array mode, 1 = read/hold, 0 = write
//        in_o    : write data to the array
//        out_i   : read data from the selected word
module ram_word_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_word_ctrl_if.slave    bus,
  output logic [DEPTH-1:0]  sel_o,
  output logic              read_o,
  output logic [WIDTH-1:0]  in_o,
  input  logic [WIDTH-1:0]  out_i
);

  state_e           state_q, state_d;
  logic             wr_q, wr_d;
  logic [DEPTH-1:0] sel_q, sel_d;
  logic             read_q, read_d;
  logic [WIDTH-1:0] in_q, in_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic [DEPTH-1:0] dec_onehot;
  logic             dec_oor;

  // Decode the incoming address only while a request can be accepted
  ram_addr_decode #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_decode (
    .en_i           ((state_q == IDLE) && bus.req_valid),
    .addr_i         (bus.req_addr),
    .onehot_o       (dec_onehot),
    .out_of_range_o (dec_oor)
  );

  // Next-state and registered-output logic.
  // The address and write data are held as sel_q / in_q from the accept
  // edge onward, so later changes on the request bus never reach the array.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    sel_d       = sel_q;
    read_d      = read_q;
    in_d        = in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d = bus.req_wr;
          if (dec_oor) begin
            // Bad address: respond on the accept edge, never touch the array
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = ACCESS;
            sel_d   = dec_onehot;
            read_d  = (bus.req_wr != OP_WR);
            in_d    = (bus.req_wr == OP_WR) ? bus.req_wdata : '0;
          end
        end
      end

      ACCESS: begin
        if (wr_q == OP_WR) begin
          // Cells store on the edge that leaves this state
          state_d     = RESP;
          sel_d       = '0;
          read_d      = 1'b1;
          in_d        = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        // Selected word has been on OUT for a full cycle; register it
        state_d     = RESP;
        sel_d       = '0;
        read_d      = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = out_i;
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops SEL and restores READ at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_q        <= OP_RD;
      sel_q       <= '0;
      read_q      <= 1'b1;
      in_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      sel_q       <= sel_d;
      read_q      <= read_d;
      in_q        <= in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Ready is held low for the whole reset pulse, not just until the next edge
  assign bus.req_ready = rst_n && (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign sel_o  = sel_q;
  assign read_o = read_q;
  assign in_o   = in_q;

endmodule

// File: tb/tb_ram_word_ctrl.sv
// Self-checking bench for ram_word_ctrl: a 16-word instance (A) and a
// 12-word instance (B, for out-of-range addresses), each with a behavioural
// 1-bit-cell array model. Directed vector table plus hand-written sequences.
module tb_ram_word_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DA    = 16;
  localparam int unsigned DB    = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_na, rst_nb, mem_clr;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Shared request drive, steered to one instance by use_b
  logic             use_b;
  logic             d_valid, d_wr, d_rsp_ready;
  logic [AW-1:0]    d_addr;
  logic [WIDTH-1:0] d_wdata;

  ram_word_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) a_if ();
  ram_word_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) b_if ();

  assign a_if.req_valid = d_valid & ~use_b;
  assign a_if.req_wr    = d_wr;
  assign a_if.req_addr  = d_addr;
  assign a_if.req_wdata = d_wdata;
  assign a_if.rsp_ready = d_rsp_ready;
  assign b_if.req_valid = d_valid & use_b;
  assign b_if.req_wr    = d_wr;
  assign b_if.req_addr  = d_addr;
  assign b_if.req_wdata = d_wdata;
  assign b_if.rsp_ready = d_rsp_ready;

  logic [DA-1:0]    a_sel;
  logic             a_read;
  logic [WIDTH-1:0] a_in, a_out;
  logic [DB-1:0]    b_sel;
  logic             b_read;
  logic [WIDTH-1:0] b_in, b_out;

  ram_word_ctrl #(.WIDTH(WIDTH), .DEPTH(DA), .AW(AW)) dut_a (
    .clk(clk), .rst_n(rst_na), .bus(a_if.slave),
    .sel_o(a_sel), .read_o(a_read), .in_o(a_in), .out_i(a_out)
  );

  ram_word_ctrl #(.WIDTH(WIDTH), .DEPTH(DB), .AW(AW)) dut_b (
    .clk(clk), .rst_n(rst_nb), .bus(b_if.slave),
    .sel_o(b_sel), .read_o(b_read), .in_o(b_in), .out_i(b_out)
  );

  // Cell array models: store on the rising edge while selected with READ=0
  logic [WIDTH-1:0] mem_a [DA];
  logic [WIDTH-1:0] mem_b [DB];

  always @(posedge clk) begin
    for (int i = 0; i < int'(DA); i++) begin
      if (mem_clr) mem_a[i] <= '0;
      else if (a_sel[i] && !a_read) mem_a[i] <= a_in;
    end
    for (int i = 0; i < int'(DB); i++) begin
      if (mem_clr) mem_b[i] <= '0;
      else if (b_sel[i] && !b_read) mem_b[i] <= b_in;
    end
  end

  always_comb begin
    a_out = '0;
    for (int i = 0; i < int'(DA); i++) if (a_sel[i]) a_out = a_out | mem_a[i];
    b_out = '0;
    for (int i = 0; i < int'(DB); i++) if (b_sel[i]) b_out = b_out | mem_b[i];
  end

  // Observed signals of the currently addressed instance
  logic [15:0]      o_sel;
  logic             o_read, o_req_ready, o_rsp_valid, o_rsp_err;
  logic [WIDTH-1:0] o_in, o_rsp_rdata;
  assign o_sel       = use_b ? {4'b0000, b_sel} : a_sel;
  assign o_read      = use_b ? b_read : a_read;
  assign o_in        = use_b ? b_in : a_in;
  assign o_req_ready = use_b ? b_if.req_ready : a_if.req_ready;
  assign o_rsp_valid = use_b ? b_if.rsp_valid : a_if.rsp_valid;
  assign o_rsp_rdata = use_b ? b_if.rsp_rdata : a_if.rsp_rdata;
  assign o_rsp_err   = use_b ? b_if.rsp_err : a_if.rsp_err;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // SEL must never be multi-hot on either instance
  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("sel_a_onehot0", 32'($onehot0(a_sel)), 32'd1);
      check("sel_b_onehot0", 32'($onehot0(b_sel)), 32'd1);
    end
  end

  typedef struct {
    bit          dut_b;
    bit          wr;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] exp_sel;
    bit          exp_read;
    logic [7:0]  exp_in;
    logic [7:0]  exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(input bit b, input bit wr, input logic [3:0] addr,
                              input logic [7:0] wdata, input logic [15:0] sel,
                              input bit rd, input logic [7:0] in_v,
                              input logic [7:0] rdata, input bit err, input int lat);
    vec_t v;
    v.dut_b = b; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_sel = sel; v.exp_read = rd; v.exp_in = in_v;
    v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat;
    return v;
  endfunction

  int unsigned last_acc;
  int          last_lat;

  // Issue one request from an IDLE negedge; returns at a negedge back in IDLE
  task automatic run_vec(input vec_t v, input bit chk_period);
    int          lat;
    int unsigned acc;
    use_b = v.dut_b;
    check("req_ready_idle", 32'(o_req_ready), 32'd1);
    d_valid = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
    @(posedge clk);
    acc = cyc;
    if (chk_period) check("accept_period", acc - last_acc, 32'(last_lat + 2));
    last_acc = acc;
    last_lat = v.exp_lat;
    @(negedge clk);
    // Scramble the bus: the array must only see the latched request
    d_valid = 1'b0; d_addr = ~v.addr; d_wdata = ~v.wdata;
    check("first_sel", 32'(o_sel), 32'(v.exp_sel));
    check("first_read", 32'(o_read), 32'(v.exp_read));
    check("first_in", 32'(o_in), 32'(v.exp_in));
    lat = 0;
    while (!o_rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
      if (!o_rsp_valid) begin
        check("capture_sel", 32'(o_sel), 32'(v.exp_sel));
        check("capture_read", 32'(o_read), 32'd1);
      end
    end
    check("rsp_valid_seen", 32'(o_rsp_valid), 32'd1);
    check("rsp_latency", 32'(lat), 32'(v.exp_lat));
    check("rsp_rdata", 32'(o_rsp_rdata), 32'(v.exp_rdata));
    check("rsp_err", 32'(o_rsp_err), 32'(v.exp_err));
    check("resp_sel_zero", 32'(o_sel), 32'd0);
    check("resp_read_hi", 32'(o_read), 32'd1);
    check("resp_req_ready", 32'(o_req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rsp_valid_cleared", 32'(o_rsp_valid), 32'd0);
  endtask

  vec_t vecs[15];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Stimulus table: writes lat 1, reads lat 2, bad addresses lat 0
    vecs[0]  = mk(0, 1, 4'd3,  8'hA5, 16'h0008, 0, 8'hA5, 8'h00, 0, 1);
    vecs[1]  = mk(0, 0, 4'd3,  8'h00, 16'h0008, 1, 8'h00, 8'hA5, 0, 2);
    vecs[2]  = mk(0, 1, 4'd7,  8'h7E, 16'h0080, 0, 8'h7E, 8'h00, 0, 1);
    vecs[3]  = mk(0, 1, 4'd0,  8'h11, 16'h0001, 0, 8'h11, 8'h00, 0, 1);
    vecs[4]  = mk(0, 0, 4'd0,  8'h00, 16'h0001, 1, 8'h00, 8'h11, 0, 2);
    vecs[5]  = mk(0, 1, 4'd15, 8'hF0, 16'h8000, 0, 8'hF0, 8'h00, 0, 1);
    vecs[6]  = mk(0, 0, 4'd15, 8'h00, 16'h8000, 1, 8'h00, 8'hF0, 0, 2);
    vecs[7]  = mk(0, 1, 4'd0,  8'h22, 16'h0001, 0, 8'h22, 8'h00, 0, 1);
    vecs[8]  = mk(0, 0, 4'd15, 8'h00, 16'h8000, 1, 8'h00, 8'hF0, 0, 2);
    vecs[9]  = mk(0, 1, 4'd15, 8'h0F, 16'h8000, 0, 8'h0F, 8'h00, 0, 1);
    vecs[10] = mk(0, 0, 4'd0,  8'h00, 16'h0001, 1, 8'h00, 8'h22, 0, 2);
    vecs[11] = mk(1, 0, 4'd13, 8'h00, 16'h0000, 1, 8'h00, 8'h00, 1, 0);
    vecs[12] = mk(1, 1, 4'd12, 8'hFF, 16'h0000, 1, 8'h00, 8'h00, 1, 0);
    vecs[13] = mk(1, 1, 4'd11, 8'hC7, 16'h0800, 0, 8'hC7, 8'h00, 0, 1);
    vecs[14] = mk(1, 0, 4'd11, 8'h00, 16'h0800, 1, 8'h00, 8'hC7, 0, 2);

    use_b = 1'b0; d_valid = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    d_rsp_ready = 1'b1; mem_clr = 1'b1;
    last_acc = 0; last_lat = 0;
    rst_na = 1'b1; rst_nb = 1'b1;
    #2;
    rst_na = 1'b0; rst_nb = 1'b0;
    #1;
    check("rst_sel", 32'(a_sel), 32'd0);
    check("rst_read", 32'(a_read), 32'd1);
    check("rst_in", 32'(a_in), 32'd0);
    check("rst_rsp_valid", 32'(a_if.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(a_if.rsp_rdata), 32'd0);
    check("rst_rsp_err", 32'(a_if.rsp_err), 32'd0);
    check("rst_req_ready", 32'(a_if.req_ready), 32'd0);
    check("rst_b_req_ready", 32'(b_if.req_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_na = 1'b1; rst_nb = 1'b1; mem_clr = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 32'(a_if.req_ready), 32'd1);
    check("post_rst_rsp_valid", 32'(a_if.rsp_valid), 32'd0);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i > 0);

    // Backpressure: hold the read response of addr 7 for five cycles
    use_b = 1'b0; d_rsp_ready = 1'b0;
    d_valid = 1'b1; d_wr = 1'b0; d_addr = 4'd7; d_wdata = 8'h00;
    @(posedge clk);
    @(negedge clk);
    d_valid = 1'b0;
    for (int k = 0; k < 8 && !o_rsp_valid; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
      check("bp_rsp_rdata", 32'(o_rsp_rdata), 32'h7E);
      check("bp_rsp_err", 32'(o_rsp_err), 32'd0);
      check("bp_req_ready", 32'(o_req_ready), 32'd0);
      check("bp_sel", 32'(o_sel), 32'd0);
      @(negedge clk);
    end
    d_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(o_req_ready), 32'd1);
    check("bp_release_valid", 32'(o_rsp_valid), 32'd0);

    // Reset during write ACCESS: strobes drop at once, no response follows
    d_valid = 1'b1; d_wr = 1'b1; d_addr = 4'd5; d_wdata = 8'h99;
    @(posedge clk);
    @(negedge clk);
    d_valid = 1'b0;
    check("mid_access_sel", 32'(a_sel), 32'h0020);
    check("mid_access_read", 32'(a_read), 32'd0);
    #2;
    rst_na = 1'b0;
    #1;
    check("abort_sel", 32'(a_sel), 32'd0);
    check("abort_read", 32'(a_read), 32'd1);
    check("abort_rsp_valid", 32'(a_if.rsp_valid), 32'd0);
    check("abort_req_ready", 32'(a_if.req_ready), 32'd0);
    @(negedge clk);
    rst_na = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(a_if.rsp_valid), 32'd0);
      check("abort_ready", 32'(a_if.req_ready), 32'd1);
    end
    // The aborted write must not have reached the cells
    run_vec(mk(0, 0, 4'd5, 8'h00, 16'h0020, 1, 8'h00, 8'h00, 0, 2), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
